// File: rtl/dif_butterfly_unit.sv
// ---------------------------------------------------------------------------
// dif_butterfly_unit
//
// Radix-2 decimation-in-frequency (Gentleman-Sande) butterfly:
//   X = A + B
//   Y = (A - B) * W       (W conjugated per sample when inv = 1)
// with optional divide-by-2 per stage (SCALE), round-half-up and saturation
// of every output component. Three register stages, valid/ready handshake.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready is combinational)
//   inv                  1 = multiply by conj(W); travels with the sample
//   a_i/a_q, b_i/b_q     complex inputs A and B, DATA_W signed each
//   w_i/w_q              complex twiddle, Q1.(TW_W-1) signed
//   out_valid/out_ready  output handshake
//   x_i/x_q, y_i/y_q     complex outputs X and Y, DATA_W signed each
//   ovf                  any of the four output components saturated
// ---------------------------------------------------------------------------
module dif_butterfly_unit #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 8,
    parameter int SCALE  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     inv,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] a_q,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic signed [DATA_W-1:0] b_q,
    input  logic signed [TW_W-1:0]   w_i,
    input  logic signed [TW_W-1:0]   w_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] x_i,
    output logic signed [DATA_W-1:0] x_q,
    output logic signed [DATA_W-1:0] y_i,
    output logic signed [DATA_W-1:0] y_q,
    output logic                     ovf
);

    // Sum/difference width, conjugated-twiddle width, product width, and a
    // working width with headroom for the cross-term add plus rounding bias.
    localparam int SW  = DATA_W + 1;
    localparam int TWW = TW_W + 1;
    localparam int PW  = DATA_W + TW_W + 2;
    localparam int RW  = PW + 2;
    localparam int SH  = TW_W - 1 + SCALE;

    localparam logic signed [RW-1:0] BIAS = RW'(1) <<< (SH - 1);

    typedef struct packed {
        logic                     sat;
        logic signed [DATA_W-1:0] val;
    } sat_t;

    // Clamp a wide value into DATA_W bits; it fits only when every bit above
    // the DATA_W-1 sign position equals the sign bit.
    function automatic sat_t saturate(input logic signed [RW-1:0] v);
        sat_t r;
        r.sat = (v[RW-1:DATA_W-1] != {(RW-DATA_W+1){v[RW-1]}});
        if (!r.sat)
            r.val = v[DATA_W-1:0];
        else if (v[RW-1])
            r.val = {1'b1, {(DATA_W-1){1'b0}}};
        else
            r.val = {1'b0, {(DATA_W-1){1'b1}}};
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Handshake: the whole pipeline moves as one; bubbles are kept.
    // ------------------------------------------------------------------
    logic en;
    logic v1_q, v2_q, out_valid_q;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // ------------------------------------------------------------------
    // Stage 1: sum, difference, conditional twiddle conjugation
    // ------------------------------------------------------------------
    logic signed [SW-1:0]  sum_re_d, sum_im_d, dif_re_d, dif_im_d;
    logic signed [TWW-1:0] tw_im_d;

    logic signed [SW-1:0]  sum_re_q, sum_im_q, dif_re_q, dif_im_q;
    logic signed [TW_W-1:0] tw_re_q;
    logic signed [TWW-1:0] tw_im_q;

    // NOTE: every always_comb output gets a value on every path, so no latch.
    always_comb begin
        sum_re_d = SW'(a_i) + SW'(b_i);
        sum_im_d = SW'(a_q) + SW'(b_q);
        dif_re_d = SW'(a_i) - SW'(b_i);
        dif_im_d = SW'(a_q) - SW'(b_q);
        // One extra bit so that negating the most negative twiddle gives +2^(TW_W-1).
        tw_im_d  = inv ? -TWW'(w_q) : TWW'(w_q);
    end

    // ------------------------------------------------------------------
    // Stage 2: four partial products of (A-B) * W'
    // ------------------------------------------------------------------
    logic signed [PW-1:0] prod_rr_d, prod_ii_d, prod_ri_d, prod_ir_d;
    logic signed [PW-1:0] prod_rr_q, prod_ii_q, prod_ri_q, prod_ir_q;
    logic signed [SW-1:0] sum2_re_q, sum2_im_q;

    always_comb begin
        prod_rr_d = PW'(dif_re_q) * PW'(tw_re_q);
        prod_ii_d = PW'(dif_im_q) * PW'(tw_im_q);
        prod_ri_d = PW'(dif_re_q) * PW'(tw_im_q);
        prod_ir_d = PW'(dif_im_q) * PW'(tw_re_q);
    end

    // ------------------------------------------------------------------
    // Stage 3: combine products, round, scale, saturate
    // ------------------------------------------------------------------
    logic signed [RW-1:0] pr, pq, yr_w, yq_w, xr_w, xq_w;
    sat_t                 sat_xr, sat_xq, sat_yr, sat_yq;
    logic                 ovf_d;

    always_comb begin
        pr   = RW'(prod_rr_q) - RW'(prod_ii_q);
        pq   = RW'(prod_ri_q) + RW'(prod_ir_q);
        // Adding half an output LSB before the arithmetic shift rounds half up.
        yr_w = (pr + BIAS) >>> SH;
        yq_w = (pq + BIAS) >>> SH;
        xr_w = (SCALE != 0) ? ((RW'(sum2_re_q) + RW'(1)) >>> 1) : RW'(sum2_re_q);
        xq_w = (SCALE != 0) ? ((RW'(sum2_im_q) + RW'(1)) >>> 1) : RW'(sum2_im_q);
        sat_xr = saturate(xr_w);
        sat_xq = saturate(xq_w);
        sat_yr = saturate(yr_w);
        sat_yq = saturate(yq_w);
        ovf_d  = sat_xr.sat | sat_xq.sat | sat_yr.sat | sat_yq.sat;
    end

    // ------------------------------------------------------------------
    // Control and output registers (reset)
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] x_re_q, x_im_q, y_re_q, y_im_q;
    logic                     ovf_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            x_re_q      <= '0;
            x_im_q      <= '0;
            y_re_q      <= '0;
            y_im_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v2_q) begin
                x_re_q <= sat_xr.val;
                x_im_q <= sat_xq.val;
                y_re_q <= sat_yr.val;
                y_im_q <= sat_yq.val;
                ovf_q  <= ovf_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: data registers carry no reset; the valid bits alone decide
    // whether their contents mean anything, so a reset tree here buys nothing.
    always_ff @(posedge clk) begin
        if (en) begin
            sum_re_q  <= sum_re_d;
            sum_im_q  <= sum_im_d;
            dif_re_q  <= dif_re_d;
            dif_im_q  <= dif_im_d;
            tw_re_q   <= w_i;
            tw_im_q   <= tw_im_d;
            sum2_re_q <= sum_re_q;
            sum2_im_q <= sum_im_q;
            prod_rr_q <= prod_rr_d;
            prod_ii_q <= prod_ii_d;
            prod_ri_q <= prod_ri_d;
            prod_ir_q <= prod_ir_d;
        end
    end

    assign out_valid = out_valid_q;
    assign x_i       = x_re_q;
    assign x_q       = x_im_q;
    assign y_i       = y_re_q;
    assign y_q       = y_im_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dif_butterfly_unit.sv
// ---------------------------------------------------------------------------
// tb_dif_butterfly_unit
//
// Directed bench for dif_butterfly_unit: a SCALE=1 instance driven through a
// scoreboard (expected results queued at input acceptance, compared at output
// transfer) and a SCALE=0 instance for the saturation case.
// ---------------------------------------------------------------------------
module tb_dif_butterfly_unit;

    localparam int DW = 16;
    localparam int TW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // SCALE = 1 instance
    logic                 rst, in_valid, in_ready, inv, out_valid, out_ready, ovf;
    logic signed [DW-1:0] a_i, a_q, b_i, b_q, x_i, x_q, y_i, y_q;
    logic signed [TW-1:0] w_i, w_q;

    // SCALE = 0 instance
    logic                 in_valid_z, in_ready_z, inv_z, out_valid_z, out_ready_z, ovf_z;
    logic signed [DW-1:0] a_i_z, a_q_z, b_i_z, b_q_z, x_i_z, x_q_z, y_i_z, y_q_z;
    logic signed [TW-1:0] w_i_z, w_q_z;

    dif_butterfly_unit #(.DATA_W(DW), .TW_W(TW), .SCALE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
        .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q), .w_i(w_i), .w_q(w_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_i(x_i), .x_q(x_q), .y_i(y_i), .y_q(y_q), .ovf(ovf)
    );

    dif_butterfly_unit #(.DATA_W(DW), .TW_W(TW), .SCALE(0)) dut_z (
        .clk(clk), .rst(rst), .in_valid(in_valid_z), .in_ready(in_ready_z), .inv(inv_z),
        .a_i(a_i_z), .a_q(a_q_z), .b_i(b_i_z), .b_q(b_q_z), .w_i(w_i_z), .w_q(w_q_z),
        .out_valid(out_valid_z), .out_ready(out_ready_z),
        .x_i(x_i_z), .x_q(x_q_z), .y_i(y_i_z), .y_q(y_q_z), .ovf(ovf_z)
    );

    typedef struct {
        int   xi, xq, yi, yq;
        logic ovf;
    } exp_t;

    exp_t sb_q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   delivered = 0;

    // Stream stimulus: a_i, a_q, b_i, b_q, w_i, w_q, inv
    int st_v [6][7] = '{
        '{  1200,   -300,     50,    700,   90,  -40, 0},
        '{ -5000,   2500,   3000,  -1000,  -77,  101, 1},
        '{ 32767, -32768, -32768,  32767, -128, -128, 0},
        '{   123,    456,   -789,   1011,  127,  127, 1},
        '{-32768, -32768, -32768, -32768,   64,  -64, 0},
        '{     7,     -9,      3,      5,   -1,    1, 1}
    };

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input int xi, xq, yi, yq, input logic o);
        exp_t e;
        e.xi = xi; e.xq = xq; e.yi = yi; e.yq = yq; e.ovf = o;
        return e;
    endfunction

    function automatic longint clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: plain integer arithmetic of the butterfly equations.
    function automatic exp_t model(input int ai, aq, bi, bq, wi, wq, input bit iv,
                                   input int scale);
        longint si, sq, di, dq, wqp, pr, pq, yr, yq, xr, xq;
        int     sh;
        exp_t   e;
        si  = longint'(ai) + bi;
        sq  = longint'(aq) + bq;
        di  = longint'(ai) - bi;
        dq  = longint'(aq) - bq;
        wqp = iv ? -longint'(wq) : longint'(wq);
        pr  = di * wi - dq * wqp;
        pq  = di * wqp + dq * wi;
        sh  = 7 + scale;
        yr  = (pr + (longint'(1) <<< (sh - 1))) >>> sh;
        yq  = (pq + (longint'(1) <<< (sh - 1))) >>> sh;
        xr  = (scale != 0) ? ((si + 1) >>> 1) : si;
        xq  = (scale != 0) ? ((sq + 1) >>> 1) : sq;
        e.ovf = (clamp16(xr) != xr) || (clamp16(xq) != xq) ||
                (clamp16(yr) != yr) || (clamp16(yq) != yq);
        e.xi = int'(clamp16(xr));
        e.xq = int'(clamp16(xq));
        e.yi = int'(clamp16(yr));
        e.yq = int'(clamp16(yq));
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int ai, aq, bi, bq, wi, wq, input bit iv, input exp_t e);
        bit rdy;
        int n;
        a_i = 16'(ai); a_q = 16'(aq); b_i = 16'(bi); b_q = 16'(bq);
        w_i = 8'(wi);  w_q = 8'(wq);  inv = iv;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        checks++;
        assert (rdy)
        else begin
            errors++;
            $error("FAIL send_accept: in_ready observed 0 expected 1 within 50 cycles");
        end
        if (rdy) sb_q.push_back(e);
    endtask

    task automatic send_m(input int k);
        send(st_v[k][0], st_v[k][1], st_v[k][2], st_v[k][3], st_v[k][4], st_v[k][5],
             st_v[k][6] != 0,
             model(st_v[k][0], st_v[k][1], st_v[k][2], st_v[k][3], st_v[k][4],
                   st_v[k][5], st_v[k][6] != 0, 1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare on every output transfer.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (sb_q.size() > 0)
            else begin
                errors++;
                $error("FAIL sb_unexpected: output observed with %0d pending, expected none", sb_q.size());
            end
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("sb_x_i", x_i, mon_e.xi);
                check("sb_x_q", x_q, mon_e.xq);
                check("sb_y_i", y_i, mon_e.yi);
                check("sb_y_q", y_q, mon_e.yq);
                check("sb_ovf", ovf, mon_e.ovf);
                delivered++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, d1, n_seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; inv = 1'b0;
        a_i = '0; a_q = '0; b_i = '0; b_q = '0; w_i = '0; w_q = '0;
        in_valid_z = 1'b0; out_ready_z = 1'b1; inv_z = 1'b0;
        a_i_z = '0; a_q_z = '0; b_i_z = '0; b_q_z = '0; w_i_z = '0; w_q_z = '0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_x_i", x_i, 0);
        check("rst_y_q", y_q, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid_z", out_valid_z, 0);
        @(posedge clk);
        #1;

        // Basic sample and latency
        send(1000, 0, 200, 0, 127, 0, 1'b0, mk(600, 0, 397, 0, 1'b0));
        in_valid = 1'b0;
        @(negedge clk); check("lat_cycle1", out_valid, 0);
        @(negedge clk); check("lat_cycle2", out_valid, 0);
        @(negedge clk); check("lat_cycle3", out_valid, 1);
        @(posedge clk);
        #1;

        // j-twiddle, plain and conjugated, back to back
        send(0, 0, -100, 0, 0, 127, 1'b0, mk(-50, 0, 0, 50, 1'b0));
        send(0, 0, -100, 0, 0, 127, 1'b1, mk(-50, 0, 0, -50, 1'b0));
        // Conjugating the most negative twiddle must give +128
        send(0, 0, -256, 0, 0, -128, 1'b1, mk(-128, 0, 0, 128, 1'b0));
        idle(6);

        // Saturation on the unscaled instance
        a_i_z = 16'sd32767; a_q_z = 16'sd32767; b_i_z = 16'sd32767; b_q_z = 16'sd32767;
        w_i_z = 8'sd127; w_q_z = 8'sd0; inv_z = 1'b0; in_valid_z = 1'b1;
        @(negedge clk);
        check("z_in_ready", in_ready_z, 1);
        @(posedge clk);
        #1;
        in_valid_z = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("z_out_valid", out_valid_z, 1);
        check("z_x_i", x_i_z, 32767);
        check("z_x_q", x_q_z, 32767);
        check("z_y_i", y_i_z, 0);
        check("z_y_q", y_q_z, 0);
        check("z_ovf", ovf_z, 1);

        // Backpressure: six back-to-back samples, 5-cycle stall on first output
        d0 = delivered;
        fork
            begin
                for (int k = 0; k < 6; k++) send_m(k);
                in_valid = 1'b0;
            end
            begin
                int n;
                logic signed [DW-1:0] sx, sy;
                n = 0;
                while (!out_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("bp_first_valid", out_valid, 1);
                out_ready = 1'b0;
                sx = x_i;
                sy = y_q;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_valid_held", out_valid, 1);
                    check("bp_x_i_held", x_i, sx);
                    check("bp_y_q_held", y_q, sy);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(10);
        check("bp_drained", sb_q.size(), 0);
        check("bp_delivered", delivered - d0, 6);

        // Reset with samples in flight
        d1 = delivered;
        send_m(0);
        send_m(3);
        a_i = 16'(st_v[5][0]); a_q = 16'(st_v[5][1]);
        b_i = 16'(st_v[5][2]); b_q = 16'(st_v[5][3]);
        w_i = 8'(st_v[5][4]);  w_q = 8'(st_v[5][5]);
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("rs_out_valid", out_valid, 0);
        check("rs_x_i", x_i, 0);
        check("rs_x_q", x_q, 0);
        check("rs_y_i", y_i, 0);
        check("rs_y_q", y_q, 0);
        check("rs_ovf", ovf, 0);
        check("rs_in_ready", in_ready, 1);
        n_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) n_seen++;
        end
        check("rs_no_stale", n_seen, 0);
        @(posedge clk);
        #1;
        send_m(1);
        idle(6);
        check("rs_drained", sb_q.size(), 0);
        check("rs_delivered", delivered - d1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
